// File: rtl/ram_rd_pkg.sv
// ram_rd_pkg: width helpers for the read-return aligner (clog2, credit/occupancy and pointer widths)
package ram_rd_pkg;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int cnt_width(input int depth);
    return clog2(depth) + 1;
  endfunction
  function automatic int ptr_width(input int depth);
    return depth > 1 ? clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/ram_rd_skid_fifo.sv
// ram_rd_skid_fifo: circular skid buffer (wr_en/wr_data in, rd_en/rd_data/empty/count out, clear flushes)
module ram_rd_skid_fifo import ram_rd_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        wr_en,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        rd_en,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        empty,
  output logic [cnt_width(DEPTH)-1:0] count
);
  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic wr, rd;
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign wr = wr_en & ~clear;
  assign rd = rd_en & ~clear & ~empty;
  assign empty = count_q == '0;
  assign count = count_q;
  assign rd_data = empty ? last_q : mem_q[rd_ptr_q];
  always_comb begin
    mem_d = mem_q;
    if (wr) mem_d[wr_ptr_q] = wr_data;
    wr_ptr_d = clear ? '0 : wr ? bump(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = clear ? '0 : rd ? bump(rd_ptr_q) : rd_ptr_q;
    count_d = clear ? '0 : count_q + CW'(wr) - CW'(rd);
    last_d = rd ? mem_q[rd_ptr_q] : last_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_q <= '{default: '0};
      last_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      last_q <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  assert property (@(posedge clk) disable iff (!rst_n) !(wr && !rd && count_q == CW'(DEPTH)));
endmodule

// File: rtl/ram_rd_return_align.sv
// ram_rd_return_align: issues credit-guarded RAM reads and realigns fixed-latency returns into a valid/ready stream
module ram_rd_return_align import ram_rd_pkg::*; #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 2,
  parameter int SKID_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  output logic                             ram_rd_en,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  input  logic [DATA_WIDTH-1:0]            ram_rdata,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [cnt_width(SKID_DEPTH)-1:0] occupancy
);
  localparam int CW = cnt_width(SKID_DEPTH);
  logic [RD_LATENCY-1:0] tag_q, tag_d;
  logic [CW-1:0] credit_q, credit_d;
  logic empty, pop;
  assign req_ready = credit_q != '0 && !clear;
  assign ram_rd_en = req_valid & req_ready;
  assign ram_addr = req_addr;
  assign out_valid = ~empty;
  assign pop = out_valid & out_ready;
  always_comb begin
    tag_d = clear ? '0 : RD_LATENCY'({tag_q, ram_rd_en});
    credit_d = clear ? CW'(SKID_DEPTH) : credit_q - CW'(ram_rd_en) + CW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tag_q <= '0;
      credit_q <= CW'(SKID_DEPTH);
    end else begin
      tag_q <= tag_d;
      credit_q <= credit_d;
    end
  ram_rd_skid_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(SKID_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .wr_en(tag_q[RD_LATENCY-1]),
    .wr_data(ram_rdata),
    .rd_en(pop),
    .rd_data(out_data),
    .empty(empty),
    .count(occupancy)
  );
endmodule

// File: tb/tb_ram_rd_return_align.sv
// tb_ram_rd_return_align: vector table plus scoreboard bench for the read-return aligner
module tb_ram_rd_return_align;
  typedef struct packed {
    logic rv;
    logic [7:0] addr;
    logic ordy;
    logic rdy;
    logic ov;
    logic [2:0] occ;
    logic [7:0] data;
    logic cd;
  } vec_t;
  logic clk = 0, rst_n = 0, clear = 0, req_valid = 0, out_ready = 0;
  logic [7:0] req_addr = 0, ram_addr, ram_rdata, out_data, a1, a2;
  logic req_ready, ram_rd_en, out_valid;
  logic [2:0] occupancy;
  int pass_cnt = 0, total_cnt = 0, acc_cnt = 0, pop_cnt = 0, ov_cnt = 0;
  logic [7:0] exp_q [$];
  vec_t vecs [12];
  always #5 clk = ~clk;
  ram_rd_return_align dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );
  always @(posedge clk) begin
    a1 <= ram_addr;
    a2 <= a1;
  end
  assign ram_rdata = a2 + 8'h40;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick();
      req_addr = req_addr + 8'd1;
    end
  endtask
  always @(negedge clk) begin
    if (out_valid) ov_cnt++;
    if (!rst_n || clear) exp_q.delete();
    else begin
      if (out_valid && out_ready) begin
        pop_cnt++;
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("sb_data", out_data, exp_q.pop_front());
      end
      if (ram_rd_en) begin
        acc_cnt++;
        exp_q.push_back(req_addr + 8'h40);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    vecs[0]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 3'd1, 8'h40, 1'b1};
    vecs[4]  = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 3'd1, 8'h41, 1'b1};
    vecs[5]  = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 3'd1, 8'h42, 1'b1};
    vecs[6]  = '{1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 3'd1, 8'h43, 1'b1};
    vecs[7]  = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 3'd1, 8'h44, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd1, 8'h45, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd1, 8'h46, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd1, 8'h47, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h47, 1'b1};
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("t1_req_ready", req_ready, 1);
    check("t1_out_valid", out_valid, 0);
    check("t1_occupancy", occupancy, 0);
    check("t1_ram_rd_en", ram_rd_en, 0);
    check("t1_out_data", out_data, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      req_valid = vecs[i].rv;
      req_addr = vecs[i].addr;
      out_ready = vecs[i].ordy;
      @(negedge clk);
      check($sformatf("t2_req_ready[%0d]", i), req_ready, vecs[i].rdy);
      check($sformatf("t2_ram_rd_en[%0d]", i), ram_rd_en, vecs[i].rv & vecs[i].rdy);
      check($sformatf("t2_out_valid[%0d]", i), out_valid, vecs[i].ov);
      check($sformatf("t2_occupancy[%0d]", i), occupancy, vecs[i].occ);
      if (vecs[i].cd) check($sformatf("t2_out_data[%0d]", i), out_data, vecs[i].data);
    end
    tick();
    req_valid = 1;
    req_addr = 8'h10;
    out_ready = 0;
    acc_cnt = 0;
    run(10);
    check("t3_accepts", acc_cnt, 4);
    check("t3_req_ready_low", req_ready, 0);
    check("t3_occupancy_full", occupancy, 4);
    out_ready = 1;
    acc_cnt = 0;
    pop_cnt = 0;
    run(24);
    check("t4_pops", pop_cnt, 24);
    check("t4_accepts", acc_cnt, 23);
    req_valid = 0;
    run(6);
    check("t4_drain_occupancy", occupancy, 0);
    check("t4_drain_out_valid", out_valid, 0);
    check("t4_drain_sb_empty", exp_q.size(), 0);
    check("t4_drain_req_ready", req_ready, 1);
    req_valid = 1;
    req_addr = 8'hA0;
    run(2);
    req_valid = 0;
    clear = 1;
    @(negedge clk);
    check("t5_ready_in_clear", req_ready, 0);
    check("t5_rd_en_in_clear", ram_rd_en, 0);
    tick();
    clear = 0;
    ov_cnt = 0;
    run(6);
    check("t5_out_valid_cycles", ov_cnt, 0);
    check("t5_occupancy", occupancy, 0);
    req_valid = 1;
    req_addr = 8'hB0;
    out_ready = 0;
    acc_cnt = 0;
    run(8);
    check("t5_credit_accepts", acc_cnt, 4);
    req_valid = 0;
    out_ready = 1;
    pop_cnt = 0;
    run(6);
    check("t5_pops", pop_cnt, 4);
    req_valid = 1;
    req_addr = 8'hC0;
    out_ready = 0;
    run(4);
    req_valid = 0;
    check("t6_pre_occupancy", occupancy, 2);
    #2 rst_n = 0;
    #1;
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_occupancy", occupancy, 0);
    check("t6_rst_req_ready", req_ready, 1);
    repeat (2) @(posedge clk);
    tick();
    rst_n = 1;
    @(negedge clk);
    check("t6_idle_out_valid", out_valid, 0);
    check("t6_idle_occupancy", occupancy, 0);
    check("t6_idle_req_ready", req_ready, 1);
    check("t6_idle_ram_rd_en", ram_rd_en, 0);
    tick();
    req_valid = 1;
    req_addr = 8'h33;
    out_ready = 1;
    pop_cnt = 0;
    run(1);
    req_valid = 0;
    run(5);
    check("t6_post_pops", pop_cnt, 1);
    check("t6_post_occupancy", occupancy, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
